uart_prog_loader: RTL and testbench

//  Upstream feeder of the instruction-fetch stage's UART programming port.

---
 rtl/uart_prog_loader_if.sv | 23 ++
 rtl/uart_prog_loader.sv | 133 +++++++++++++
 tb/tb_uart_prog_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// UART programming port bundle: received-byte strobe in, memory-programming signals out.
// The master side feeds bytes; the slave side (the loader) drives the upg_* outputs.
interface uart_prog_loader_if;
    logic        rx_valid_i;
    logic [7:0]  rx_byte_i;
    logic        upg_rst_o;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output rx_valid_i, rx_byte_i,
        input  upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o
    );

    modport slave (
        input  rx_valid_i, rx_byte_i,
        output upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Frames a UART byte stream into 32-bit memory writes; write strobe follows the 4th byte of a word by 1 cycle.
// No backpressure: every rx_valid_i strobe is consumed in the cycle it arrives.
module uart_prog_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 2_000_000
) (
    input logic               clock,
    input logic               reset,
    uart_prog_loader_if.slave upg
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEG, S_LEN_L, S_LEN_H, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          seg;
    logic [7:0]    len_l;
    logic [14:0]   words_left;
    logic [13:0]   idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   pack;
    logic [7:0]    csum;
    logic          in_frame;
    logic [15:0]   len_w;

    assign in_frame = (state == S_SEG) || (state == S_LEN_L) || (state == S_LEN_H) ||
                      (state == S_DATA) || (state == S_CSUM);
    assign len_w    = {upg.rx_byte_i, len_l};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            tmo_cnt        <= '0;
            seg            <= 1'b0;
            len_l          <= '0;
            words_left     <= '0;
            idx            <= '0;
            byte_cnt       <= '0;
            pack           <= '0;
            csum           <= '0;
            upg.upg_rst_o  <= 1'b1;
            upg.upg_wen_o  <= 1'b0;
            upg.upg_adr_o  <= '0;
            upg.upg_dat_o  <= '0;
            upg.upg_done_o <= 1'b0;
            upg.err_o      <= 1'b0;
            upg.busy_o     <= 1'b0;
        end else begin
            upg.upg_wen_o <= 1'b0;
            // Timeout takes priority; a byte landing in the same cycle is dropped.
            if (in_frame && (tmo_cnt == TW'(TIMEOUT_CYCLES))) begin
                state          <= S_ERR;
                upg.err_o      <= 1'b1;
                upg.upg_rst_o  <= 1'b1;
                upg.upg_done_o <= 1'b0;
                upg.busy_o     <= 1'b0;
            end else begin
                if (in_frame)
                    tmo_cnt <= upg.rx_valid_i ? '0 : tmo_cnt + TW'(1);
                if (upg.rx_valid_i) begin
                    if (in_frame)
                        csum <= csum ^ upg.rx_byte_i;
                    case (state)
                        S_IDLE, S_DONE, S_ERR: begin
                            if (upg.rx_byte_i == SYNC_BYTE) begin
                                state          <= S_SEG;
                                tmo_cnt        <= '0;
                                csum           <= '0;
                                upg.upg_rst_o  <= 1'b0;
                                upg.upg_done_o <= 1'b0;
                                upg.err_o      <= 1'b0;
                                upg.busy_o     <= 1'b1;
                            end
                        end
                        S_SEG: begin
                            seg   <= upg.rx_byte_i[0];
                            state <= S_LEN_L;
                        end
                        S_LEN_L: begin
                            len_l <= upg.rx_byte_i;
                            state <= S_LEN_H;
                        end
                        S_LEN_H: begin
                            if ((len_w == 16'd0) || (len_w > 16'd16384)) begin
                                state          <= S_ERR;
                                upg.err_o      <= 1'b1;
                                upg.upg_rst_o  <= 1'b1;
                                upg.upg_done_o <= 1'b0;
                                upg.busy_o     <= 1'b0;
                            end else begin
                                words_left <= len_w[14:0];
                                idx        <= '0;
                                byte_cnt   <= '0;
                                state      <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            // Right shift lands the first byte of each word in [7:0].
                            byte_cnt <= byte_cnt + 2'd1;
                            pack     <= {upg.rx_byte_i, pack[23:8]};
                            if (byte_cnt == 2'd3) begin
                                upg.upg_wen_o <= 1'b1;
                                upg.upg_adr_o <= {seg, idx};
                                upg.upg_dat_o <= {upg.rx_byte_i, pack};
                                idx           <= idx + 14'd1;
                                words_left    <= words_left - 15'd1;
                                if (words_left == 15'd1)
                                    state <= S_CSUM;
                            end
                        end
                        S_CSUM: begin
                            upg.upg_rst_o <= 1'b1;
                            upg.busy_o    <= 1'b0;
                            if (upg.rx_byte_i == csum) begin
                                state          <= S_DONE;
                                upg.upg_done_o <= 1'b1;
                                upg.err_o      <= 1'b0;
                            end else begin
                                state          <= S_ERR;
                                upg.upg_done_o <= 1'b0;
                                upg.err_o      <= 1'b1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized frame stimulus checked against a byte-level frame model; writes are captured by a monitor.
module tb_uart_prog_loader;
    localparam int TMO = 200;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_prog_loader_if bus ();

    uart_prog_loader #(
        .SYNC_BYTE      (8'h5A),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .upg   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int gap_max  = 2;

    logic [14:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic        wr_rst[$];
    logic [31:0] words[$];

    always @(negedge clock) begin
        if (bus.upg_wen_o === 1'b1) begin
            wr_adr.push_back(bus.upg_adr_o);
            wr_dat.push_back(bus.upg_dat_o);
            wr_rst.push_back(bus.upg_rst_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid_i = 1'b1;
        bus.rx_byte_i  = b;
        @(posedge clock);
        #1;
        bus.rx_valid_i = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(posedge clock);
        #1;
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic rst, input logic busy);
        check({tag, " done"}, 32'(bus.upg_done_o), 32'(done));
        check({tag, " err"},  32'(bus.err_o),      32'(err));
        check({tag, " rst"},  32'(bus.upg_rst_o),  32'(rst));
        check({tag, " busy"}, 32'(bus.busy_o),     32'(busy));
    endtask

    // Model: a legal LEN yields LEN writes at {seg[0], i} carrying words[i];
    // the frame succeeds only when LEN is legal and the checksum is unaltered.
    task automatic run_frame(input string tag, input logic [7:0] seg_b,
                             input logic [15:0] len, input logic [7:0] flip);
        int          base;
        int          n_exp;
        int          bad;
        bit          legal;
        bit          ok;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        logic [14:0] ea;
        base  = wr_adr.size();
        legal = (len >= 16'd1) && (len <= 16'd16384);
        ok    = legal && (flip == 8'd0);
        n_exp = legal ? int'(len) : 0;
        cs    = seg_b ^ len[7:0] ^ len[15:8];
        send_byte(8'h5A);
        send_byte(seg_b);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (legal) begin
            for (int i = 0; i < int'(len); i++) begin
                w = words[i];
                for (int k = 0; k < 4; k++) begin
                    b  = w[8*k +: 8];
                    cs = cs ^ b;
                    send_byte(b);
                end
            end
            send_byte(cs ^ flip);
        end
        repeat (2) @(posedge clock);
        #1;
        check({tag, " wr_count"}, 32'(wr_adr.size() - base), 32'(n_exp));
        if (wr_adr.size() - base == n_exp) begin
            if (n_exp <= 16) begin
                for (int i = 0; i < n_exp; i++) begin
                    ea = {seg_b[0], 14'(i)};
                    check({tag, $sformatf(" adr%0d", i)}, 32'(wr_adr[base+i]), 32'(ea));
                    check({tag, $sformatf(" dat%0d", i)}, wr_dat[base+i], words[i]);
                    check({tag, $sformatf(" rst@wr%0d", i)}, 32'(wr_rst[base+i]), 32'd0);
                end
            end else begin
                bad = 0;
                for (int i = 0; i < n_exp; i++) begin
                    ea = {seg_b[0], 14'(i)};
                    if (wr_adr[base+i] !== ea || wr_dat[base+i] !== words[i] || wr_rst[base+i] !== 1'b0)
                        bad++;
                end
                check({tag, " bad_writes"}, 32'(bad), 32'd0);
                check({tag, " last_adr"}, 32'(wr_adr[base+n_exp-1]), 32'({seg_b[0], 14'h3FFF}));
            end
        end
        check_status(tag, ok, !ok, 1'b1, 1'b0);
    endtask

    initial begin
        int          base;
        int          waited;
        logic [7:0]  flip;
        logic [15:0] rlen;

        reset          = 1'b1;
        bus.rx_valid_i = 1'b0;
        bus.rx_byte_i  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset wen", 32'(bus.upg_wen_o), 32'd0);
        check("reset adr", 32'(bus.upg_adr_o), 32'd0);
        check("reset dat", bus.upg_dat_o, 32'd0);
        check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);

        // Idle ignores anything but the sync byte.
        send_byte(8'h11);
        send_byte(8'hA5);
        send_byte(8'hFF);
        check_status("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        words = '{32'h12345678, 32'hDEADBEEF};
        run_frame("t1", 8'h00, 16'd2, 8'h00);
        run_frame("t2", 8'h01, 16'd2, 8'h00);
        run_frame("t3", 8'h00, 16'd2, 8'h01);

        // Timeout with one byte of the only word delivered.
        base = wr_adr.size();
        send_byte(8'h5A);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        check("t4 busy mid", 32'(bus.busy_o), 32'd1);
        check("t4 rst mid", 32'(bus.upg_rst_o), 32'd0);
        waited = 0;
        while (bus.err_o !== 1'b1 && waited < TMO + 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check("t4 timeout seen", 32'(waited < TMO + 50), 32'd1);
        check("t4 wr_count", 32'(wr_adr.size() - base), 32'd0);
        check_status("t4", 1'b0, 1'b1, 1'b1, 1'b0);

        run_frame("t5 len0", 8'h00, 16'd0, 8'h00);
        run_frame("t5 len16385", 8'h00, 16'd16385, 8'h00);

        // Reset after six data bytes: only the first word lands.
        base = wr_adr.size();
        send_byte(8'h5A);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hEF);
        send_byte(8'hBE);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6 wr_count", 32'(wr_adr.size() - base), 32'd1);
        if (wr_adr.size() > base) begin
            check("t6 adr0", 32'(wr_adr[base]), 32'd0);
            check("t6 dat0", wr_dat[base], 32'h12345678);
        end
        check("t6 wen", 32'(bus.upg_wen_o), 32'd0);
        check("t6 adr", 32'(bus.upg_adr_o), 32'd0);
        check("t6 dat", bus.upg_dat_o, 32'd0);
        check_status("t6 reset", 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("t6 reload", 8'h00, 16'd2, 8'h00);

        // Sync byte inside the payload is plain data; SEG bits 7:1 are ignored.
        words = '{32'h5A5A5A5A, 32'h0000005A};
        run_frame("t7", 8'hFE, 16'd2, 8'h00);

        for (int r = 0; r < 6; r++) begin
            rlen = 16'($urandom_range(1, 6));
            fill_random(int'(rlen));
            flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame($sformatf("rnd%0d", r), 8'($urandom), rlen, flip);
        end

        // Largest legal frame ends exactly at word index 0x3FFF.
        gap_max = 0;
        fill_random(16384);
        run_frame("t9 max", 8'h00, 16'd16384, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
